// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM data-memory back end: FSM encoding and parameter defaults.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BASE_ADDR_DEFAULT   = 1024;
    localparam int SRAM_AW_DEFAULT     = 18;
    localparam int WAIT_CYCLES_DEFAULT = 2;

    // Byte address to 32-bit word index relative to the start of the SRAM window.
    function automatic logic [31:0] word_offset(input logic [31:0] address,
                                                input logic [31:0] base);
        return (address - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: load/store request, returned data and ready.
interface sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );

endinterface

// File: rtl/sram_read_buffer.sv
// One-entry read buffer {valid, word tag, data}; filled by load misses, kept coherent by stores.
module sram_read_buffer #(
    parameter int TAG_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic             fill_en,
    input  logic             store_en,
    input  logic [TAG_W-1:0] update_tag,
    input  logic [31:0]      update_data,
    output logic             hit,
    output logic [31:0]      data
);

    logic             valid;
    logic [TAG_W-1:0] tag;

    // A fill replaces the entry; a store only touches it when it targets the buffered word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= update_tag;
            data  <= update_data;
        end else if (store_en && valid && (tag == update_tag)) begin
            data  <= update_data;
        end
    end

    assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit asynchronous SRAM accesses.
// Optional one-entry read buffer enabled by defining SRAM_READ_BUFFER_EN.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int SRAM_AW     = SRAM_AW_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [15:0]        sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n
);

    localparam int CNT_W  = $clog2(WAIT_CYCLES);
    localparam int WORD_W = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic               ready;
    logic               start;

    logic               req_write;
    logic [WORD_W-1:0]  req_word;
    logic [31:0]        req_data;
    logic [15:0]        lo_half;
    logic [31:0]        read_data_q;

    logic               dq_drive;
    logic [15:0]        dq_out;

    logic [31:0]        offset;
    logic [WORD_W-1:0]  in_word;
    logic               unused_offset;

    logic               buf_hit;
    logic [31:0]        buf_data;

    logic               cur_write;
    logic [WORD_W-1:0]  cur_word;
    logic [31:0]        cur_data;
    logic               next_active;
    logic               next_last;

    assign offset        = word_offset(bus.address, 32'(BASE_ADDR));
    assign in_word       = offset[WORD_W-1:0];
    assign unused_offset = ^offset[31:WORD_W];

`ifdef SRAM_READ_BUFFER_EN
    logic buf_tag_hit;

    sram_read_buffer #(
        .TAG_W(WORD_W)
    ) u_read_buffer (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (in_word),
        .fill_en    ((state == DONE) && !req_write),
        .store_en   ((state == DONE) && req_write),
        .update_tag (req_word),
        .update_data(req_write ? req_data : read_data_q),
        .hit        (buf_tag_hit),
        .data       (buf_data)
    );

    assign buf_hit       = (state == IDLE) && bus.rd_en && !bus.wr_en && buf_tag_hit;
    assign bus.read_data = buf_hit ? buf_data : read_data_q;
`else
    assign buf_hit       = 1'b0;
    assign buf_data      = 32'h0;
    assign bus.read_data = read_data_q;
`endif

    assign start     = (bus.rd_en || bus.wr_en) && !buf_hit;
    assign bus.ready = ready;
    assign sram_ce_n = 1'b0;
    assign sram_dq   = dq_drive ? dq_out : 16'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = !start;
                if (start) begin
                    next_state = LO;
                    next_cnt   = '0;
                end
            end
            LO: begin
                if (wait_cnt == LAST_CNT) begin
                    next_state = HI;
                    next_cnt   = '0;
                end else begin
                    next_cnt = wait_cnt + CNT_W'(1);
                end
            end
            HI: begin
                if (wait_cnt == LAST_CNT) begin
                    next_state = DONE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = wait_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // In IDLE the request comes straight from the bus; afterwards from the latched copy.
    always_comb begin
        cur_write   = req_write;
        cur_word    = req_word;
        cur_data    = req_data;
        if (state == IDLE) begin
            cur_write = bus.wr_en;
            cur_word  = in_word;
            cur_data  = bus.write_data;
        end
        next_active = (next_state == LO) || (next_state == HI);
        next_last   = (next_cnt == LAST_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_write <= 1'b0;
            req_word  <= '0;
            req_data  <= '0;
        end else if ((state == IDLE) && start) begin
            req_write <= bus.wr_en;
            req_word  <= in_word;
            req_data  <= bus.write_data;
        end
    end

    // Load capture: low half at the end of LO, full word at the end of HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_half     <= '0;
            read_data_q <= '0;
        end else begin
            if (buf_hit) begin
                read_data_q <= buf_data;
            end
            if ((state == LO) && (wait_cnt == LAST_CNT) && !req_write) begin
                lo_half <= sram_dq;
            end
            if ((state == HI) && (wait_cnt == LAST_CNT) && !req_write) begin
                read_data_q <= {sram_dq, lo_half};
            end
        end
    end

    // Pads are registered from the next state so the SRAM sees glitch-free strobes;
    // we_n rises one cycle before address/data move on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr <= '0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            dq_drive  <= 1'b0;
            dq_out    <= '0;
        end else begin
            if (next_active) begin
                sram_addr <= {cur_word, next_state == HI};
            end
            sram_we_n <= !(next_active && cur_write && !next_last);
            sram_oe_n <= !(next_active && !cur_write);
            dq_drive  <= next_active && cur_write;
            dq_out    <= (next_state == HI) ? cur_data[31:16] : cur_data[15:0];
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural asynchronous SRAM on the pads.
module tb_sram_controller;

`ifdef SRAM_READ_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          low;
        int          we_low;
        int          oe_low;
    } exp_t;

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    tri1  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;

    logic [15:0] mem [0:255] = '{default: 16'h0000};
    logic [15:0] mem_rd;

    int errors = 0;
    int checks = 0;
    int we_low_cnt = 0;
    int oe_low_cnt = 0;

    exp_t        sb[$];
    wr_t         exp_wr[$];
    wr_t         wr_log[$];
    logic [31:0] model [int];
    bit          buf_valid = 1'b0;
    int          buf_tag = 0;

    sram_controller_if bus();

    sram_controller dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .sram_dq  (sram_dq),
        .sram_addr(sram_addr),
        .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n)
    );

    always #5 clk = ~clk;

    always_comb mem_rd = mem[sram_addr[7:0]];
    assign sram_dq = (!sram_oe_n && !sram_ce_n) ? mem_rd : 16'bz;

    // SRAM write port and pad activity log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!sram_we_n && !sram_ce_n) begin
            mem[sram_addr[7:0]] = sram_dq;
            wr_log.push_back({sram_addr, sram_dq});
            we_low_cnt++;
        end
        if (!sram_oe_n) begin
            oe_low_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        exp_t got;
        int   word;
        int   low;
        bit   hit;
        word     = int'((addr - 32'd1024) >> 2);
        e.is_load = !wr;
        e.data    = 32'h0;
        if (wr) begin
            e.low    = 5;
            e.we_low = 2;
            e.oe_low = 0;
            exp_wr.push_back({18'(2 * word), data[15:0]});
            exp_wr.push_back({18'(2 * word + 1), data[31:16]});
            model[int'(addr)] = data;
        end else begin
            hit      = BUF_EN && buf_valid && (buf_tag == word);
            e.low    = hit ? 0 : 5;
            e.we_low = 0;
            e.oe_low = hit ? 0 : 4;
            e.data   = model.exists(int'(addr)) ? model[int'(addr)] : 32'h0;
            if (!hit) begin
                buf_valid = 1'b1;
                buf_tag   = word;
            end
        end
        sb.push_back(e);

        @(negedge clk);
        #1;
        we_low_cnt = 0;
        oe_low_cnt = 0;
        wr_log.delete();
        bus.rd_en      = rd;
        bus.wr_en      = wr;
        bus.address    = addr;
        bus.write_data = data;
        #1;
        low = 0;
        while (!bus.ready && low < 50) begin
            low++;
            @(negedge clk);
            #1;
        end
        if (low >= 50) begin
            checkOutput("ready_timeout", 32'(bus.ready), 32'd1);
        end

        got = sb.pop_front();
        checkOutput("ready_low_cycles", 32'(low), 32'(got.low));
        if (got.is_load) begin
            checkOutput("read_data", bus.read_data, got.data);
        end
        checkOutput("we_low_cycles", 32'(we_low_cnt), 32'(got.we_low));
        checkOutput("oe_low_cycles", 32'(oe_low_cnt), 32'(got.oe_low));
        checkOutput("write_count", 32'(wr_log.size()), 32'(exp_wr.size()));
        for (int i = 0; exp_wr.size() > 0; i++) begin
            wr_t w;
            w = exp_wr.pop_front();
            if (i < wr_log.size()) begin
                checkOutput("write_addr", 32'(wr_log[i].addr), 32'(w.addr));
                checkOutput("write_dq", 32'(wr_log[i].data), 32'(w.data));
            end
        end

        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        logic [31:0] a;
        logic [31:0] d;

        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = 32'd1024;
        bus.write_data = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(bus.ready), 32'd1);
        checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("rst_oe_n", 32'(sram_oe_n), 32'd1);
        checkOutput("rst_ce_n", 32'(sram_ce_n), 32'd0);
        checkOutput("rst_dq_z", 32'(sram_dq), 32'h0000FFFF);
        checkOutput("rst_read_data", bus.read_data, 32'h0);

        $display("[TB] store, load and repeated load");
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);

        $display("[TB] conflicting request");
        applyStimulus(1'b1, 1'b1, 32'd1032, 32'h0000CAFE);
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(8, 15));
            a = 32'(1024 + 4 * k);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(1'b0, 1'b1, a, d);
            end else begin
                applyStimulus(1'b1, 1'b0, a, 32'h0);
            end
        end

        $display("[TB] reset in the second HI cycle of a store");
        @(negedge clk);
        #1;
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1036;
        bus.write_data = 32'h11112222;
        repeat (4) @(negedge clk);
        #1;
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        #1;
        checkOutput("midrst_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("midrst_dq_z", 32'(sram_dq), 32'h0000FFFF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(bus.ready), 32'd1);
        checkOutput("midrst_read_data", bus.read_data, 32'h0);
        model[1036] = 32'h11112222;
        buf_valid   = 1'b0;

        applyStimulus(1'b1, 1'b0, 32'd1036, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
